spi_settings_responder: RTL and testbench

SPI peripheral (slave) that terminates frames from an external SPI master (host MCU, or another FPGA's SPI core driving `sen`/`sclk`/`mosi`) and converts them into settings-bus writes and readback requests on the radio control plane. It is the far end of the daughterboard SPI link: the block sits beside the radio core's settings bus and gives an external controller the same register access the host has over RFNoC. SCLK is oversampled in the `clk` domain, so no second clock is used.

---
 rtl/spi_settings_responder_pkg.sv | 11 +
 rtl/spi_settings_responder_if.sv | 12 +
 rtl/synchronizer.sv | 16 +
 rtl/spi_settings_responder.sv | 78 +++++++
 tb/tb_spi_settings_responder.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/spi_settings_responder_pkg.sv
// spi_settings_responder_pkg: frame geometry, readback filler and FSM encoding
package spi_settings_responder_pkg;
  localparam int FRAME_BITS = 48;
  localparam int HDR_BITS = 16;
  localparam int HDR_RNW_BIT = 15;
  localparam int CLK_PER_SCLK_MIN = 8;
  localparam logic [31:0] BADRB_DEF = 32'h0BADC0DE;
  localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);
  typedef enum logic [2:0] {IDLE, HEADER, WR_DATA, RD_WAIT, RD_DATA, DRAIN} state_t;
endpackage

// File: rtl/spi_settings_responder_if.sv
// spi_settings_responder_if: SPI pins plus settings/readback bus of the responder
interface spi_settings_responder_if;
  logic sen, sclk, mosi, miso, miso_oe;
  logic set_stb, rb_req, rb_stb;
  logic [7:0] set_addr, rb_addr;
  logic [31:0] set_data, rb_data;
  logic [15:0] frame_err_cnt;
  modport slave (input sen, sclk, mosi, rb_stb, rb_data,
                 output miso, miso_oe, set_stb, set_addr, set_data, rb_addr, rb_req, frame_err_cnt);
  modport master (output sen, sclk, mosi, rb_stb, rb_data,
                  input miso, miso_oe, set_stb, set_addr, set_data, rb_addr, rb_req, frame_err_cnt);
endinterface

// File: rtl/synchronizer.sv
// synchronizer: two-flop synchronizer with per-bit reset value
module synchronizer #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  // two-stage shift into the clk domain
  always_ff @(posedge clk)
    if (!reset_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_settings_responder.sv
// spi_settings_responder: oversampled SPI slave turning 48-bit frames into settings writes and readbacks
module spi_settings_responder
  import spi_settings_responder_pkg::*;
#(
  parameter logic [31:0] BADRB = BADRB_DEF
) (
  input logic clk,
  input logic reset_n,
  spi_settings_responder_if.slave bus
);
  state_t state, state_next;
  logic [2:0] sync_q;
  logic sen_s, sclk_s, mosi_s, sen_d, sclk_d;
  logic sclk_rise, sclk_fall, sen_fall, sen_rise;
  logic active, last_hdr, last_bit, abort;
  logic [5:0] cnt;
  logic [38:0] rx;
  logic [39:0] rx_next;
  logic [31:0] tx, rd_word;

  synchronizer #(.WIDTH(3), .RST_VAL(3'b100)) u_sync (
    .clk(clk), .reset_n(reset_n), .d({bus.sen, bus.sclk, bus.mosi}), .q(sync_q)
  );

  assign {sen_s, sclk_s, mosi_s} = sync_q;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign sen_fall = ~sen_s & sen_d;
  assign sen_rise = sen_s & ~sen_d;
  assign active = state inside {HEADER, WR_DATA, RD_WAIT, RD_DATA};
  assign last_hdr = sclk_rise && cnt == HDR_LAST;
  assign last_bit = sclk_rise && cnt == FRAME_LAST;
  assign rx_next = {rx, mosi_s};
  assign rd_word = bus.rb_stb ? bus.rb_data : BADRB;
  assign abort = active && sen_rise && state_next == IDLE;

  // state register and edge-detect history
  always_ff @(posedge clk)
    if (!reset_n) {state, sen_d, sclk_d} <= {IDLE, 1'b1, 1'b0};
    else {state, sen_d, sclk_d} <= {state_next, sen_s, sclk_s};

  // next state: a completing rise wins over a coincident sen_rise
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = sen_fall ? HEADER : IDLE;
      HEADER:  state_next = sen_rise ? IDLE : last_hdr ? (rx_next[HDR_RNW_BIT] ? RD_WAIT : WR_DATA) : HEADER;
      WR_DATA: state_next = last_bit ? DRAIN : sen_rise ? IDLE : WR_DATA;
      RD_WAIT: state_next = sen_rise ? IDLE : (sclk_fall || bus.rb_stb) ? RD_DATA : RD_WAIT;
      RD_DATA: state_next = last_bit ? DRAIN : sen_rise ? IDLE : RD_DATA;
      DRAIN:   state_next = sen_s ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end

  // shift registers, strobes, readback load and error counter
  always_ff @(posedge clk)
    if (!reset_n) begin
      {cnt, rx, tx} <= '0;
      {bus.miso, bus.miso_oe, bus.set_stb, bus.rb_req} <= '0;
      {bus.set_addr, bus.set_data, bus.rb_addr, bus.frame_err_cnt} <= '0;
    end else begin
      bus.miso_oe <= ~sen_s;
      bus.set_stb <= state == WR_DATA && state_next == DRAIN;
      bus.rb_req <= state == HEADER && state_next == RD_WAIT;
      if (state == IDLE && sen_fall) {cnt, rx} <= '0;
      else if (active && sclk_rise) {cnt, rx} <= {cnt + 6'd1, rx_next[38:0]};
      if (state == HEADER && state_next == RD_WAIT) bus.rb_addr <= rx_next[7:0];
      if (state == WR_DATA && state_next == DRAIN) {bus.set_addr, bus.set_data} <= rx_next;
      if (state == RD_WAIT && state_next == RD_DATA) begin
        tx <= sclk_fall ? {rd_word[30:0], 1'b0} : bus.rb_data;
        bus.miso <= sclk_fall & rd_word[31];
      end else if (state == RD_DATA && state_next == RD_DATA) begin
        if (sclk_fall) {bus.miso, tx} <= {tx, 1'b0};
      end else bus.miso <= 1'b0;
      if (abort && ~&bus.frame_err_cnt) bus.frame_err_cnt <= bus.frame_err_cnt + 16'd1;
    end
endmodule

// File: tb/tb_spi_settings_responder.sv
// tb_spi_settings_responder: directed and randomized SPI frames checked against a transaction-level model
module tb_spi_settings_responder;
  localparam logic [31:0] LATE_WORD = 32'h0BADC0DE;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  spi_settings_responder_if bus ();
  spi_settings_responder dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int stb_cnt = 0, req_cnt = 0;
  logic [7:0] got_saddr = '0;
  logic [31:0] got_sdata = '0;
  int exp_stb = 0, exp_req = 0, exp_err = 0;
  logic [7:0] exp_saddr = '0, exp_raddr = '0;
  logic [31:0] exp_sdata = '0;
  bit late_mode = 1'b0;
  int late_timer = 0;

  // observe strobes once per cycle away from the active edge
  always @(negedge clk) begin
    if (bus.set_stb) begin
      stb_cnt++;
      got_saddr = bus.set_addr;
      got_sdata = bus.set_data;
    end
    if (bus.rb_req) req_cnt++;
  end

  // readback responder: tied high, or a single pulse 20 cycles after rb_req
  initial begin
    bus.rb_stb = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rb_stb = late_mode ? (late_timer == 1) : 1'b1;
      if (late_mode && bus.rb_req) late_timer = 20;
      else if (late_timer > 0) late_timer--;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [47:0] f, input int n, input bit hold, output logic [31:0] rd);
    rd = '0;
    bus.sen = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      bus.mosi = (i < 48) ? f[47 - i] : 1'($urandom);
      tick(4);
      if (i >= 16 && i < 48) rd = {rd[30:0], bus.miso};
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
    if (!hold) begin
      tick(4);
      bus.sen = 1'b1;
      bus.mosi = 1'b0;
      tick(12);
    end
  endtask

  task automatic frame(input string tag, input bit rnw, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] rbd, input bit late, input int n);
    logic [31:0] rd;
    bus.rb_data = rbd;
    late_mode = late;
    xfer({rnw, 7'($urandom), a, d}, n, 1'b0, rd);
    if (n < 48) exp_err++;
    if (rnw && n >= 16) begin
      exp_req++;
      exp_raddr = a;
    end
    if (!rnw && n >= 48) begin
      exp_stb++;
      exp_saddr = a;
      exp_sdata = d;
    end
    if (rnw && n >= 48) chk({tag, " miso_word"}, 64'(rd), 64'(late ? LATE_WORD : rbd));
    chk({tag, " set_stb_count"}, 64'(stb_cnt), 64'(exp_stb));
    chk({tag, " rb_req_count"}, 64'(req_cnt), 64'(exp_req));
    chk({tag, " frame_err_cnt"}, 64'(bus.frame_err_cnt), 64'(exp_err));
    chk({tag, " rb_addr"}, 64'(bus.rb_addr), 64'(exp_raddr));
    if (!rnw && n >= 48) begin
      chk({tag, " set_addr"}, 64'(got_saddr), 64'(exp_saddr));
      chk({tag, " set_data"}, 64'(got_sdata), 64'(exp_sdata));
    end
    late_mode = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bus.sen = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.rb_data = '0;
    tick(4);
    chk("reset outputs", {bus.miso, bus.miso_oe, bus.set_stb, bus.rb_req, bus.set_addr, bus.rb_addr, bus.frame_err_cnt}, 64'd0);
    chk("reset set_data", 64'(bus.set_data), 64'd0);
    reset_n = 1'b1;
    tick(4);
    frame("write", 1'b0, 8'h2A, 32'hDEADBEEF, 32'h0, 1'b0, 48);
    frame("read_comb", 1'b1, 8'h10, 32'h0, 32'h12345678, 1'b0, 48);
    frame("read_late", 1'b1, 8'h33, 32'h0, 32'hCAFEF00D, 1'b1, 48);
    frame("abort", 1'b0, 8'h44, 32'h01020304, 32'h0, 1'b0, 30);
    frame("after_abort", 1'b0, 8'h45, 32'hA5A55A5A, 32'h0, 1'b0, 48);
    frame("overlong", 1'b0, 8'h56, 32'h76543210, 32'h0, 1'b0, 56);
    frame("back_to_back", 1'b0, 8'h57, 32'hFEDCBA98, 32'h0, 1'b0, 48);
    bus.rb_data = 32'hFFFF0000;
    xfer({1'b1, 7'd0, 8'h99, 32'h0}, 24, 1'b1, rd);
    chk("miso_oe in frame", 64'(bus.miso_oe), 64'd1);
    reset_n = 1'b0;
    tick(1);
    chk("mid_read reset outputs", {bus.miso, bus.miso_oe, bus.set_stb, bus.rb_req, bus.set_addr, bus.rb_addr, bus.frame_err_cnt}, 64'd0);
    chk("mid_read reset set_data", 64'(bus.set_data), 64'd0);
    bus.sen = 1'b1;
    bus.sclk = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(4);
    exp_req++;
    exp_raddr = '0;
    exp_err = 0;
    frame("post_reset_read", 1'b1, 8'h21, 32'h0, 32'h89ABCDEF, 1'b0, 48);
    frame("post_reset_write", 1'b0, 8'h22, 32'h13579BDF, 32'h0, 1'b0, 48);
    for (int k = 0; k < 10; k++)
      frame($sformatf("rand%0d", k), 1'($urandom), 8'($urandom), $urandom, $urandom, 1'($urandom), 48);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
